// File: rtl/pattern_scan_arb.sv
// pattern_scan_arb: two-requester round-robin arbiter feeding a serial bit-pattern match counter
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          asynchronous active-low reset
//   req_valid_i  per-requester word valid
//   req_data0_i  requester 0 word
//   req_data1_i  requester 1 word
//   req_ready_o  per-requester accept (one-hot or zero, only in IDLE)
//   busy_o       high while a word is being scanned or reported
//   done_o       one-cycle result strobe
//   count_o      match count of the last completed word (held until next done)
//   grant_id_o   requester that owned the last completed word
module pattern_scan_arb #(
    parameter int                 WORD_W  = 8,
    parameter int                 PAT_LEN = 5,
    parameter logic [PAT_LEN-1:0] PATTERN = 5'b11010,
    parameter int                 CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid_i,
    input  logic [WORD_W-1:0] req_data0_i,
    input  logic [WORD_W-1:0] req_data1_i,
    output logic [1:0]        req_ready_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              grant_id_o
);
    localparam int BIT_W = $clog2(WORD_W + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        SHIFT = 3'b010,
        DONE  = 3'b100
    } state_t;

    state_t             state, state_n;
    logic               last_grant;
    logic [1:0]         grant;
    logic               xfer;
    logic [WORD_W-1:0]  word;
    logic [PAT_LEN-1:0] win, win_n;
    logic [BIT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               gid;
    logic               hit;
    logic               last_bit;

    // On contention the requester that did not win last time gets the grant.
    assign grant       = (req_valid_i == 2'b11) ? (last_grant ? 2'b01 : 2'b10) : req_valid_i;
    // Gated by rst so nothing is offered while reset is held.
    assign req_ready_o = (state == IDLE && rst) ? grant : 2'b00;
    assign xfer        = |(req_valid_i & req_ready_o);
    // Window holds the most recent bits, oldest at the MSB.
    assign win_n       = {win[PAT_LEN-2:0], word[WORD_W-1]};
    // bit_cnt counts bits already in the window; this cycle adds one more.
    assign hit         = (bit_cnt >= BIT_W'(PAT_LEN - 1)) && (win_n == PATTERN);
    assign cnt_n       = (hit && cnt != '1) ? cnt + 1'b1 : cnt;
    assign last_bit    = bit_cnt == BIT_W'(WORD_W - 1);
    assign busy_o      = (state == SHIFT) || (state == DONE);
    assign done_o      = state == DONE;

    always_comb begin
        state_n = IDLE;
        case (state)
            IDLE:    state_n = xfer ? SHIFT : IDLE;
            SHIFT:   state_n = last_bit ? DONE : SHIFT;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= 1'b1;
            word       <= '0;
            win        <= '0;
            bit_cnt    <= '0;
            cnt        <= '0;
            gid        <= 1'b0;
            count_o    <= '0;
            grant_id_o <= 1'b0;
        end else if (xfer) begin
            word       <= req_ready_o[1] ? req_data1_i : req_data0_i;
            gid        <= req_ready_o[1];
            last_grant <= req_ready_o[1];
            win        <= '0;
            bit_cnt    <= '0;
            cnt        <= '0;
        end else if (state == SHIFT) begin
            word    <= word << 1;
            win     <= win_n;
            bit_cnt <= bit_cnt + 1'b1;
            cnt     <= cnt_n;
            // Result registers only move at the end of a word, so they hold between strobes.
            if (last_bit) begin
                count_o    <= cnt_n;
                grant_id_o <= gid;
            end
        end
    end
endmodule

// File: tb/tb_pattern_scan_arb.sv
// tb_pattern_scan_arb: table-driven and scoreboard bench for pattern_scan_arb
module tb_pattern_scan_arb;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid_i;
    logic [7:0] req_data0_i, req_data1_i;
    logic [1:0] req_ready_o, ready_alt;
    logic       busy_o, done_o, grant_id_o, busy_alt, done_alt, gid_alt;
    logic [3:0] count_o, count_alt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic       gid;
        logic [3:0] c;
        logic [3:0] a;
        int         cyc;
    } sb_t;
    sb_t q[$];

    typedef struct {
        logic       rq;
        logic [7:0] d;
        logic [3:0] c;
        logic [3:0] a;
    } vec_t;
    vec_t tbl[9];

    pattern_scan_arb dut (
        .clk(clk), .rst(rst), .req_valid_i(req_valid_i),
        .req_data0_i(req_data0_i), .req_data1_i(req_data1_i),
        .req_ready_o(req_ready_o), .busy_o(busy_o), .done_o(done_o),
        .count_o(count_o), .grant_id_o(grant_id_o)
    );

    pattern_scan_arb #(.PATTERN(5'b10101)) u_alt (
        .clk(clk), .rst(rst), .req_valid_i(req_valid_i),
        .req_data0_i(req_data0_i), .req_data1_i(req_data1_i),
        .req_ready_o(ready_alt), .busy_o(busy_alt), .done_o(done_alt),
        .count_o(count_alt), .grant_id_o(gid_alt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] model(input logic [7:0] w, input logic [4:0] p);
        logic [4:0] win = '0;
        logic [3:0] n = '0;
        for (int i = 0; i < 8; i++) begin
            win = {win[3:0], w[7-i]};
            if (i >= 4 && win == p) n++;
        end
        return n;
    endfunction

    logic [3:0] last_c, last_a;
    logic       last_g;

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ({done_o, busy_o, count_o, grant_id_o, req_ready_o} != 0) begin
                errors++;
                $display("FAIL reset_outputs: got done=%b busy=%b count=%0d gid=%b ready=%b want all 0",
                         done_o, busy_o, count_o, grant_id_o, req_ready_o);
            end
            last_c = '0;
            last_a = '0;
            last_g = 1'b0;
        end else begin
            checks++;
            if (req_ready_o == 2'b11 || (busy_o && req_ready_o != 2'b00)) begin
                errors++;
                $display("FAIL ready_excl: got ready=%b busy=%b", req_ready_o, busy_o);
            end
            checks++;
            if (done_alt !== done_o) begin
                errors++;
                $display("FAIL alt_done: got %b want %b", done_alt, done_o);
            end
            if (done_o) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: got done at cycle %0d want none", cyc);
                end else begin
                    sb_t e;
                    e = q.pop_front();
                    if (count_o !== e.c || count_alt !== e.a || grant_id_o !== e.gid || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL result: got count=%0d alt=%0d gid=%b cyc=%0d want count=%0d alt=%0d gid=%b cyc=%0d",
                                 count_o, count_alt, grant_id_o, cyc, e.c, e.a, e.gid, e.cyc);
                    end
                    last_c = e.c;
                    last_a = e.a;
                    last_g = e.gid;
                end
            end else begin
                checks++;
                if (count_o !== last_c || count_alt !== last_a || grant_id_o !== last_g) begin
                    errors++;
                    $display("FAIL hold: got count=%0d alt=%0d gid=%b want count=%0d alt=%0d gid=%b",
                             count_o, count_alt, grant_id_o, last_c, last_a, last_g);
                end
            end
        end
    end

    task automatic xfer(input logic g, input logic [3:0] c, input logic [3:0] a, output int t);
        int n = 0;
        logic [1:0] exp_r;
        exp_r = g ? 2'b10 : 2'b01;
        @(negedge clk);
        while (!(|(req_ready_o & req_valid_i)) && n < 40) begin
            n++;
            @(negedge clk);
        end
        t = cyc;
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL xfer_timeout: got no transfer want grant %b", exp_r);
        end else begin
            if (req_ready_o !== exp_r) begin
                errors++;
                $display("FAIL grant: got %b want %b", req_ready_o, exp_r);
            end
            q.push_back('{gid: g, c: c, a: a, cyc: cyc + 9});
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending want 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        int t, t_rel, t_prev;
        tbl[0] = '{rq: 1'b0, d: 8'b00011010, c: 4'd1, a: 4'd0};
        tbl[1] = '{rq: 1'b0, d: 8'hFF,       c: 4'd0, a: 4'd0};
        tbl[2] = '{rq: 1'b0, d: 8'b11011010, c: 4'd1, a: 4'd0};
        tbl[3] = '{rq: 1'b1, d: 8'b10101010, c: 4'd0, a: 4'd2};
        tbl[4] = '{rq: 1'b1, d: 8'b00000011, c: 4'd0, a: 4'd0};
        tbl[5] = '{rq: 1'b1, d: 8'b01000000, c: 4'd0, a: 4'd0};
        tbl[6] = '{rq: 1'b0, d: 8'b01010101, c: 4'd0, a: 4'd2};
        tbl[7] = '{rq: 1'b1, d: 8'b11010110, c: 4'd1, a: 4'd1};
        tbl[8] = '{rq: 1'b0, d: 8'b00110101, c: 4'd1, a: 4'd1};
        rst = 1'b1;
        req_valid_i = 2'b00;
        req_data0_i = '0;
        req_data1_i = '0;
        #1 rst = 1'b0;
        req_valid_i = 2'b01;
        req_data0_i = tbl[0].d;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        t_rel = cyc;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1 req_valid_i = tbl[i].rq ? 2'b10 : 2'b01;
                if (tbl[i].rq) req_data1_i = tbl[i].d;
                else req_data0_i = tbl[i].d;
            end
            xfer(tbl[i].rq, tbl[i].c, tbl[i].a, t);
            if (i == 0) begin
                checks++;
                if (t != t_rel) begin
                    errors++;
                    $display("FAIL first_xfer: got cycle %0d want %0d", t, t_rel);
                end
            end
            @(posedge clk);
            #1 req_valid_i = 2'b00;
            req_data0_i = ~req_data0_i;
            req_data1_i = ~req_data1_i;
            drain();
        end
        @(posedge clk);
        #1 rst = 1'b0;
        req_data0_i = 8'b00011010;
        req_data1_i = 8'b11010110;
        req_valid_i = 2'b11;
        @(posedge clk);
        #1 rst = 1'b1;
        t_prev = 0;
        for (int k = 0; k < 4; k++) begin
            logic g;
            g = k[0];
            xfer(g, model(g ? req_data1_i : req_data0_i, 5'b11010),
                 model(g ? req_data1_i : req_data0_i, 5'b10101), t);
            if (k > 0) begin
                checks++;
                if (t - t_prev != 10) begin
                    errors++;
                    $display("FAIL alt_spacing: got %0d want 10", t - t_prev);
                end
            end
            t_prev = t;
        end
        @(posedge clk);
        #1 req_valid_i = 2'b00;
        drain();
        @(posedge clk);
        #1 req_valid_i = 2'b01;
        req_data0_i = 8'b00011010;
        xfer(1'b0, 4'd1, 4'd0, t);
        @(posedge clk);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1 checks++;
        if ({done_o, busy_o, count_o, grant_id_o, req_ready_o} != 0) begin
            errors++;
            $display("FAIL midshift_reset: got done=%b busy=%b count=%0d gid=%b ready=%b want all 0",
                     done_o, busy_o, count_o, grant_id_o, req_ready_o);
        end
        q.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        req_valid_i = 2'b00;
        repeat (12) @(negedge clk);
        @(posedge clk);
        #1 req_valid_i = 2'b10;
        req_data1_i = 8'b11011010;
        xfer(1'b1, 4'd1, 4'd0, t);
        @(posedge clk);
        #1 req_valid_i = 2'b00;
        drain();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
